// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider serving the EX stage's DIV/DIVU requests.
// The result is packed as {remainder, quotient}. It is registered and held until EX drops start_i.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               op1_neg;
  logic               op2_neg;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];

  // The partial remainder is always below the divisor. The shifted value therefore needs
  // only one extra bit, and bit WIDTH of the difference is the borrow flag.
  assign trial = {rem_q, dividend_q[WIDTH-1]} - {1'b0, divisor_q};

  // Sign flags are stored only for signed divides, so an unsigned divide never takes a fixup.
  assign quot_fix = (sign1_q ^ sign2_q) ? -dividend_q : dividend_q;
  assign rem_fix  = sign1_q ? -rem_q : rem_q;

  // NOTE: sequential state uses non-blocking assignments only. Every register, including the
  // datapath, is cleared on reset so an aborted divide leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FREE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: state_d = S_END;
      S_ON: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else if (cnt_q == CW'(WIDTH)) begin
          state_d = S_END;
        end
      end
      S_END: begin
        if (!start_i) begin
          state_d = S_FREE;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    sign1_d    = sign1_q;
    sign2_d    = sign2_q;
    result_d   = result_q;
    ready_d    = ready_q;
    unique case (state_q)
      S_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          sign1_d    = op1_neg;
          sign2_d    = op2_neg;
          dividend_d = op1_neg ? -opdata1_i : opdata1_i;
          divisor_d  = op2_neg ? -opdata2_i : opdata2_i;
          rem_d      = '0;
          cnt_d      = '0;
        end
      end
      S_BYZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
      end
      S_ON: begin
        if (annul_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          cnt_d    = '0;
        end else if (cnt_q != CW'(WIDTH)) begin
          // The quotient bits shift into the dividend register as the dividend bits shift out.
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
          end else begin
            rem_d = {rem_q[WIDTH-2:0], dividend_q[WIDTH-1]};
          end
          dividend_d = {dividend_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d      = cnt_q + CW'(1);
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
        end
      end
      S_END: begin
        if (!start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      sign1_q    <= sign1_d;
      sign2_q    <= sign2_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit. It covers unsigned and signed quotients, divide by zero,
// annul, overflow and mid-operation reset, checking both latency and the result.
module tb_div_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           start_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;

  int vectors    = 0;
  int miscompares = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One edge, with outputs sampled 1ns later, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises a request and counts edges until ready_o. Operands are scrambled after the load
  // edge. The result is checked while start_i is held, then again after start_i drops.
  task automatic run_div(input string tag, input logic sd, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp, input int exp_lat);
    int lat = 0;
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    while (lat < 60) begin
      tick();
      lat++;
      if (lat == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
      if (ready_o) break;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result_o, exp);
    tick();
    check({tag, " hold ready"}, 64'(ready_o), 64'd1);
    check({tag, " hold result"}, result_o, exp);
    start_i = 1'b0;
    tick();
    check({tag, " release ready"}, 64'(ready_o), 64'd0);
    check({tag, " release result"}, result_o, 64'd0);
  endtask

  initial begin
    int saw_ready;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_div("udiv 100/7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34);
    tick();
    run_div("sdiv -7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    tick();
    run_div("sdiv 7/-2", 1'b1, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 34);
    tick();
    run_div("div by zero", 1'b0, 32'd1234, 32'd0, 64'd0, 2);
    tick();

    // Annul in the middle of a long divide: edge 10 samples annul_i.
    signed_div_i = 1'b0;
    opdata1_i    = 32'hFFFF_FFFF;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    for (int e = 1; e < 10; e++) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    start_i = 1'b0;
    check("annul ready", 64'(ready_o), 64'd0);
    check("annul result", result_o, 64'd0);
    saw_ready = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (ready_o) saw_ready = 1;
    end
    check("annul never ready", 64'(saw_ready), 64'd0);
    run_div("udiv 9/3 after annul", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 34);
    tick();

    run_div("sdiv overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34);
    tick();
    run_div("udiv max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 34);
    tick();

    // Reset sampled on edge 20 of an operation.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    for (int e = 1; e < 20; e++) tick();
    rst     = 1'b1;
    start_i = 1'b0;
    tick();
    check("mid reset ready", 64'(ready_o), 64'd0);
    check("mid reset result", result_o, 64'd0);
    rst = 1'b0;
    tick();
    run_div("udiv 1000/10 after reset", 1'b0, 32'd1000, 32'd10, {32'h0, 32'd100}, 34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider; the responder to the EX stage's divide request.
- EX holds div_start high and stalls the pipeline until div_ready is returned.
- Result format: remainder in the upper half, quotient in the lower half. EX writes these to HI and LO respectively.
- Supports signed (DIV) and unsigned (DIVU) division; the request can be annulled by an exception flush.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
signed_div_i  in  1  1 = signed (two's complement) divide, 0 = unsigned.
opdata1_i  in  WIDTH  dividend.
opdata2_i  in  WIDTH  divisor.
start_i  in  1  request; held high by EX until ready_o is seen.
annul_i  in  1  cancel the in-flight divide (pipeline flush).
result_o  out  2*WIDTH  {remainder, quotient}.
ready_o  out  1  result valid.

Behaviour:
- Reset: rst=1 at any edge, including mid-operation, sets:
  - state=FREE, result_o=0, ready_o=0, cnt=0;
  - all internal registers to 0.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 and annul_i=0: latch signed_div_i and both operands.
    - Divisor==0: go to BYZERO.
    - Otherwise: go to ON, cnt=0. Load the dividend register with the absolute value of opdata1_i if signed and negative, else raw. Same rule for the divisor.
  - start_i=0, or annul_i=1: stay in FREE with outputs at 0. annul_i wins over simultaneous start_i.
- BYZERO: next edge goes to END with result_o=0 and ready_o=1.
- ON, cnt<WIDTH: one iteration per edge, then cnt++. Iteration:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor from the partial remainder (WIDTH+1-bit subtract).
  - If non-negative: keep the difference and shift in quotient bit 1; else shift in 0.
- ON, cnt==WIDTH:
  - Signed: negate the quotient if sign1^sign2. Negate the remainder if sign1 (remainder takes the dividend's sign).
  - Write result_o and set ready_o=1; go to END.
- ON, annul_i=1: go to FREE at the next edge, ready_o=0, result_o=0; the partial result is discarded.
- END: hold result_o and ready_o while start_i=1. When start_i=0, the next edge goes to FREE with ready_o=0 and result_o=0.
- Latency, counted in rising edges from and including the edge that samples start_i in FREE:
  - Normal divide: ready_o rises after edge 34 (1 load + 32 iterations + 1 fixup).
  - Divide by zero: ready_o rises after edge 2.
- Back-to-back: a new request is accepted only from FREE. At least one cycle with start_i=0 is required between requests.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap.
- Operand inputs are ignored after the load edge; changes on them mid-operation do not affect the result.
- ready_o and result_o are registered, with no combinational path from inputs.

Test Plan:
1. Unsigned 100/7 (signed_div_i=0): ready_o rises after edge 34; result_o = {0x00000002, 0x0000000E}.
2. Signed -7/2 (0xFFFFFFF9, 0x00000002): result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/-2: {0x00000001, 0xFFFFFFFD}.
3. Divide by zero (opdata2_i=0): ready_o rises after edge 2; result_o = 0. Holding start_i keeps ready_o=1; dropping start_i clears ready_o after the next edge.
4. Annul: start unsigned 0xFFFFFFFF/3, assert annul_i for one cycle at edge 10. ready_o never rises and the state returns to FREE. A fresh 9/3 request then yields {0, 3} after 34 edges.
5. Signed 0x80000000/0xFFFFFFFF: result_o = {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF/1: {0, 0xFFFFFFFF}.
6. Reset at edge 20 of an operation: ready_o=0 and result_o=0 the next cycle. A subsequent request completes with correct latency.
